serial_cla_adder: RTL



---
 rtl/serial_cla_pkg.sv | 19 +
 rtl/serial_cla_adder_cla_group.sv | 43 ++++
 rtl/serial_cla_adder.sv | 131 +++++++++++++
 3 files changed

// File: rtl/serial_cla_pkg.sv
// Shared types and sizing helpers for the digit-serial lookahead adder.
// Optional subtract mode is enabled with SERIAL_CLA_SUBTRACT_EN.
package serial_cla_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_cla_adder_cla_group.sv
// One DIGIT-bit carry-lookahead group built from per-bit g/p terms.
// Purely combinational; also exposes the carry into the top bit.
module cla_group #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             c_top
);

    logic [DIGIT-1:0] g;
    logic [DIGIT-1:0] p;
    logic [DIGIT:0]   c;
    logic             ci;
    logic             pp;

    // each carry is a flat sum of products over lower g/p terms
    always_comb begin
        g  = x & y;
        p  = x | y;
        c  = '0;
        ci = 1'b0;
        pp = 1'b1;
        c[0] = cin;
        for (int i = 1; i <= DIGIT; i++) begin
            ci = 1'b0;
            pp = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                ci = ci | (pp & g[j]);
                pp = pp & p[j];
            end
            c[i] = ci | (pp & cin);
        end
    end

    assign s     = x ^ y ^ c[DIGIT-1:0];
    assign cout  = c[DIGIT];
    assign c_top = c[DIGIT-1];

endmodule

// File: rtl/serial_cla_adder.sv
// Digit-serial adder: DIGIT bits per cycle, registered carry between digits.
// Define SERIAL_CLA_SUBTRACT_EN to add the sub port (a - b - c_in).
module serial_cla_adder
    import serial_cla_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef SERIAL_CLA_SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int N  = num_digits(WIDTH, DIGIT);
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t state, state_d;

    logic [WIDTH-1:0]       a_sh;
    logic [WIDTH-1:0]       b_sh;
    logic [WIDTH-1:0]       sum_sh;
    logic [WIDTH+DIGIT-1:0] sum_cat;
    logic [WIDTH-1:0]       sum_nxt;
    logic                   carry;
    logic [CW-1:0]          cnt;
    logic                   sub_in;
    logic                   sub_q;
    logic                   accept;
    logic                   last;

    logic [DIGIT-1:0] g_s;
    logic             g_cout;
    logic             g_ctop;

`ifdef SERIAL_CLA_SUBTRACT_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    cla_group #(
        .DIGIT(DIGIT)
    ) u_grp (
        .x    (a_sh[DIGIT-1:0]),
        .y    (b_sh[DIGIT-1:0]),
        .cin  (carry),
        .s    (g_s),
        .cout (g_cout),
        .c_top(g_ctop)
    );

    // digit sum enters at the MSB end, so after N digits it is aligned
    assign sum_cat = {g_s, sum_sh};
    assign sum_nxt = sum_cat[WIDTH+DIGIT-1:DIGIT];
    assign accept  = (state == IDLE) && in_valid;
    assign last    = (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid) state_d = RUN;
            end
            RUN: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // subtraction is a + ~b + ~c_in; borrow is the inverted final carry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sub_q  <= 1'b0;
            sum    <= '0;
            c_out  <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= sub_in ? ~b : b;
            carry <= sub_in ? ~c_in : c_in;
            sub_q <= sub_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh   <= a_sh >> DIGIT;
            b_sh   <= b_sh >> DIGIT;
            sum_sh <= sum_nxt;
            carry  <= g_cout;
            cnt    <= cnt + 1'b1;
            if (last) begin
                sum   <= sum_nxt;
                c_out <= g_cout ^ sub_q;
                ovf   <= g_ctop ^ g_cout;
            end
        end
    end

endmodule
